float_add_pipe: RTL and testbench

//  Pipelined, parametrised floating-point adder/subtractor with valid/ready handshake for the convolution datapath.

---
 rtl/float_pkg.sv | 24 ++
 rtl/float_lzc.sv | 20 ++
 rtl/float_add_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_float_add_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Width helpers shared by the parametrised floating-point adder and its normaliser.
package float_pkg;

  localparam int EXP_W_DEFAULT = 5;
  localparam int MAN_W_DEFAULT = 10;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int frac_w(input int man_w);
    return man_w + 1;
  endfunction

  // The all-ones exponent field is reserved, so the largest finite one is one below it.
  function automatic int exp_max_finite(input int exp_w);
    return (1 << exp_w) - 2;
  endfunction

  function automatic int lzc_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module float_lzc
  import float_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int CNT_W = lzc_w(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      cnt = din[i] ? CNT_W'(WIDTH - 1 - i) : cnt;
    end
  end

endmodule

// File: rtl/float_add_pipe.sv
// Three-stage floating-point add/sub (align, add, normalise) with truncation,
// overflow saturation, underflow flush and a sideband tag.
module float_add_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4,
  localparam int W = word_w(EXP_W, MAN_W),
  localparam int FRAC_W = frac_w(MAN_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic             out_udf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LZ_W = lzc_w(FRAC_W);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]     EXP_SAT  = EXP_W'(exp_max_finite(EXP_W));

  logic adv_s;
  assign adv_s    = !out_valid | out_ready;
  assign in_ready = adv_s;

  logic sa_s, sb_s, za_s, zb_s, sgna_s, sgnb_s;
  logic [EXP_W-1:0] ea_s, eb_s, diff_s, exp1_s;
  logic [MAN_W-1:0] ma_s, mb_s;
  logic [FRAC_W-1:0] fa_s, fb_s;

  // Align: zero operands pass the other through; otherwise shift the smaller-exponent fraction.
  always_comb begin
    sa_s   = in_a[W-1];
    sb_s   = in_b[W-1] ^ in_sub;
    ea_s   = in_a[W-2:MAN_W];
    eb_s   = in_b[W-2:MAN_W];
    ma_s   = in_a[MAN_W-1:0];
    mb_s   = in_b[MAN_W-1:0];
    za_s   = (ea_s == '0);
    zb_s   = (eb_s == '0);
    diff_s = '0;
    exp1_s = '0;
    fa_s   = '0;
    fb_s   = '0;
    sgna_s = 1'b0;
    sgnb_s = 1'b0;
    if (za_s && zb_s) begin
      exp1_s = '0;
    end else if (za_s) begin
      exp1_s = eb_s;
      fb_s   = {1'b1, mb_s};
      sgna_s = sb_s;
      sgnb_s = sb_s;
    end else if (zb_s) begin
      exp1_s = ea_s;
      fa_s   = {1'b1, ma_s};
      sgna_s = sa_s;
      sgnb_s = sa_s;
    end else if (ea_s >= eb_s) begin
      diff_s = ea_s - eb_s;
      exp1_s = ea_s;
      fa_s   = {1'b1, ma_s};
      fb_s   = (int'(diff_s) > MAN_W) ? '0 : ({1'b1, mb_s} >> diff_s);
      sgna_s = sa_s;
      sgnb_s = sb_s;
    end else begin
      diff_s = eb_s - ea_s;
      exp1_s = eb_s;
      fa_s   = (int'(diff_s) > MAN_W) ? '0 : ({1'b1, ma_s} >> diff_s);
      fb_s   = {1'b1, mb_s};
      sgna_s = sa_s;
      sgnb_s = sb_s;
    end
  end

  logic              v1_r, sgna_r, sgnb_r;
  logic [TAG_W-1:0]  tag1_r;
  logic [EXP_W-1:0]  exp1_r;
  logic [FRAC_W-1:0] fa_r, fb_r;

  // Stage 1 register: aligned operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r   <= 1'b0;
      tag1_r <= '0;
      exp1_r <= '0;
      fa_r   <= '0;
      fb_r   <= '0;
      sgna_r <= 1'b0;
      sgnb_r <= 1'b0;
    end else if (adv_s) begin
      v1_r   <= in_valid;
      tag1_r <= in_tag;
      exp1_r <= exp1_s;
      fa_r   <= fa_s;
      fb_r   <= fb_s;
      sgna_r <= sgna_s;
      sgnb_r <= sgnb_s;
    end
  end

  logic [FRAC_W:0] sum2_s;
  logic            sign2_s;

  // Add magnitudes on matching signs, else subtract the smaller; a tie is an exact +0.
  always_comb begin
    sum2_s  = '0;
    sign2_s = 1'b0;
    if (sgna_r == sgnb_r) begin
      sum2_s  = {1'b0, fa_r} + {1'b0, fb_r};
      sign2_s = sgna_r;
    end else if (fa_r > fb_r) begin
      sum2_s  = {1'b0, fa_r - fb_r};
      sign2_s = sgna_r;
    end else if (fb_r > fa_r) begin
      sum2_s  = {1'b0, fb_r - fa_r};
      sign2_s = sgnb_r;
    end else begin
      sum2_s  = '0;
      sign2_s = 1'b0;
    end
  end

  logic             v2_r, sign2_r, zero2_r;
  logic [TAG_W-1:0] tag2_r;
  logic [EXP_W-1:0] exp2_r;
  logic [FRAC_W:0]  sum2_r;

  // Stage 2 register: raw sum with common exponent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_r    <= 1'b0;
      tag2_r  <= '0;
      exp2_r  <= '0;
      sum2_r  <= '0;
      sign2_r <= 1'b0;
      zero2_r <= 1'b0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      tag2_r  <= tag1_r;
      exp2_r  <= exp1_r;
      sum2_r  <= sum2_s;
      sign2_r <= sign2_s;
      zero2_r <= (sum2_s == '0);
    end
  end

  logic [LZ_W-1:0]        lz_s;
  logic signed [XW-1:0]   exp_ext_s, exp3_s;
  logic [MAN_W-1:0]       man3_s;
  logic [W-1:0]           sum3_s;
  logic                   ovf3_s, udf3_s;

  float_lzc #(.WIDTH(FRAC_W), .CNT_W(LZ_W)) u_lzc (
    .din (sum2_r[FRAC_W-1:0]),
    .cnt (lz_s)
  );

  // Normalise; the hidden bit falls off the top of the shifted mantissa.
  always_comb begin
    exp_ext_s = signed'({2'b00, exp2_r});
    exp3_s    = exp_ext_s;
    man3_s    = '0;
    sum3_s    = '0;
    ovf3_s    = 1'b0;
    udf3_s    = 1'b0;
    if (sum2_r[FRAC_W]) begin
      exp3_s = exp_ext_s + XW'(1);
      man3_s = sum2_r[MAN_W:1];
    end else begin
      exp3_s = exp_ext_s - XW'(lz_s);
      man3_s = sum2_r[MAN_W-1:0] << lz_s;
    end
    if (zero2_r) begin
      sum3_s = '0;
    end else if (exp3_s >= EXP_TOP) begin
      sum3_s = {sign2_r, EXP_SAT, {MAN_W{1'b1}}};
      ovf3_s = 1'b1;
    end else if (exp3_s <= EXP_ZERO) begin
      sum3_s = '0;
      udf3_s = 1'b1;
    end else begin
      sum3_s = {sign2_r, exp3_s[EXP_W-1:0], man3_s};
    end
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_udf   <= 1'b0;
      out_tag   <= '0;
    end else if (adv_s) begin
      out_valid <= v2_r;
      out_sum   <= sum3_s;
      out_ovf   <= ovf3_s;
      out_udf   <= udf3_s;
      out_tag   <= tag2_r;
    end
  end

endmodule

// File: tb/tb_float_add_pipe.sv
// Directed checks of float_add_pipe at EXP_W=5, MAN_W=10 with hand-computed results.
module tb_float_add_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic        out_udf;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  float_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_udf   (out_udf),
    .out_tag   (out_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One op through an idle pipeline with out_ready=1; checks 3-clock latency and the result.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [3:0] tag, input logic [15:0] exp_sum,
                        input logic exp_ovf, input logic exp_udf);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 check_eq({name, ".early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq({name, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({name, ".sum"}, 32'(out_sum), 32'(exp_sum));
    check_eq({name, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
    check_eq({name, ".udf"}, 32'(out_udf), 32'(exp_udf));
    check_eq({name, ".tag"}, 32'(out_tag), 32'(tag));
  endtask

  logic [15:0] bp_a   [4] = '{16'h3C00, 16'h3C00, 16'h4200, 16'h3C00};
  logic [15:0] bp_b   [4] = '{16'h4000, 16'h1400, 16'h3C00, 16'hBC00};
  logic        bp_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] bp_exp [3] = '{16'h4200, 16'h3C01, 16'h4000};

  initial begin
    int acc;
    int n_got;
    int stale;
    logic [15:0] got_sum [8];
    logic [3:0]  got_tag [8];

    #12;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.sum", 32'(out_sum), 32'd0);
    check_eq("rst.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("add1",    16'h3C00, 16'h4000, 1'b0, 4'h5, 16'h4200, 1'b0, 1'b0);
    run_op("sub1",    16'h4200, 16'h3C00, 1'b1, 4'h1, 16'h4000, 1'b0, 1'b0);
    run_op("cancel",  16'h3C00, 16'hBC00, 1'b0, 4'h2, 16'h0000, 1'b0, 1'b0);
    run_op("trunc10", 16'h3C00, 16'h1400, 1'b0, 4'h3, 16'h3C01, 1'b0, 1'b0);
    run_op("trunc11", 16'h3C00, 16'h1000, 1'b0, 4'h4, 16'h3C00, 1'b0, 1'b0);
    run_op("negzero", 16'h8000, 16'h4000, 1'b0, 4'h6, 16'h4000, 1'b0, 1'b0);
    run_op("subzero", 16'h0000, 16'h4000, 1'b1, 4'h7, 16'hC000, 1'b0, 1'b0);
    run_op("ovf",     16'h7BFF, 16'h7BFF, 1'b0, 4'h8, 16'h7BFF, 1'b1, 1'b0);
    run_op("udf",     16'h0401, 16'h0400, 1'b1, 4'h9, 16'h0000, 1'b0, 1'b1);

    // Back-pressure: consumer stalled while four ops are offered.
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a = bp_a[acc]; in_b = bp_b[acc]; in_sub = bp_sub[acc]; in_tag = 4'(acc + 1);
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    check_eq("bp.accepted", 32'(acc), 32'd3);
    check_eq("bp.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        got_sum[n_got] = out_sum;
        got_tag[n_got] = out_tag;
        n_got++;
      end
      @(negedge clk);
    end
    check_eq("bp.count", 32'(n_got), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp.sum%0d", i), 32'(got_sum[i]), 32'(bp_exp[i]));
      check_eq($sformatf("bp.tag%0d", i), 32'(got_tag[i]), 32'(i + 1));
    end

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = bp_a[i]; in_b = bp_b[i]; in_sub = bp_sub[i]; in_tag = 4'hA;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("inflight.valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst.valid", 32'(out_valid), 32'd0);
    check_eq("arst.sum", 32'(out_sum), 32'd0);
    check_eq("arst.tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("arst.stale", 32'(stale), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
